vga_timing_gen: RTL and testbench

- Parametrised raster timing generator; successor to the fixed 640x480 hsync/vsync pair.
- Single clock domain with an internal pixel-clock-enable divider. There is no derived clock, and vsync is no longer clocked from hsync.
- Produces registered sync, blank, data-enable, pixel coordinates, and line/frame/vblank strobes.
- Feeds the image generator and game logic. The game logic updates on the vblank strobe.

---
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: a pixel-enable divider drives the h/v counters.
// All outputs are registered from the decode of the current counter value on each pixel tick.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 18,
  parameter int H_SYNC   = 94,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_pix_en,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_blank,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic             o_vblank_start
);

  localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW1   = CNT_W + 1;

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $fatal(1, "vga_timing_gen: CLK_DIV must be >= 1");
    end
    if ((H_TOT > (1 << CNT_W)) || (V_TOT > (1 << CNT_W))) begin : g_bad_width
      $fatal(1, "vga_timing_gen: CNT_W too narrow for H_TOT/V_TOT");
    end
    if ((H_SYNC < 1) || (V_SYNC < 1)) begin : g_bad_sync
      $fatal(1, "vga_timing_gen: sync widths must be >= 1");
    end
  endgenerate

  // Decode thresholds are one bit wider so a sync end equal to 2^CNT_W still fits.
  localparam logic [CW1-1:0] H_ACT_C  = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0] HS_START = CW1'(H_ACTIVE + H_FRONT);
  localparam logic [CW1-1:0] HS_END   = CW1'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW1-1:0] V_ACT_C  = CW1'(V_ACTIVE);
  localparam logic [CW1-1:0] VS_START = CW1'(V_ACTIVE + V_FRONT);
  localparam logic [CW1-1:0] VS_END   = CW1'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CW1-1:0]   h_ext;
  logic [CW1-1:0]   v_ext;
  logic             active;
  logic             hs_act;
  logic             vs_act;
  logic             h_zero;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    h_ext  = {1'b0, h_cnt};
    v_ext  = {1'b0, v_cnt};
    active = (h_ext < H_ACT_C) && (v_ext < V_ACT_C);
    hs_act = (h_ext >= HS_START) && (h_ext < HS_END);
    vs_act = (v_ext >= VS_START) && (v_ext < VS_END);
    h_zero = (h_cnt == '0);
  end

  // Level outputs only move on a tick and hold in between.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hsync <= ~HS_ON;
      o_vsync <= ~VS_ON;
      o_blank <= 1'b1;
      o_de    <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
    end else if (tick) begin
      o_hsync <= hs_act ? HS_ON : ~HS_ON;
      o_vsync <= vs_act ? VS_ON : ~VS_ON;
      o_blank <= ~active;
      o_de    <= active;
      o_x     <= active ? h_cnt : '0;
      o_y     <= active ? v_cnt : '0;
    end
  end

  // Strobes are re-evaluated every edge so they last exactly one clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_en       <= 1'b0;
      o_line_start   <= 1'b0;
      o_frame_start  <= 1'b0;
      o_vblank_start <= 1'b0;
    end else begin
      o_pix_en       <= tick;
      o_line_start   <= tick && h_zero;
      o_frame_start  <= tick && h_zero && (v_cnt == '0);
      o_vblank_start <= tick && h_zero && (v_ext == V_ACT_C);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a tiny raster at CLK_DIV=1,
// and inverted polarity with default horizontal timing over a short frame.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b0;
  logic rst_s = 1'b0;
  logic rst_p = 1'b0;

  logic        d_pix_en, d_hs, d_vs, d_blank, d_de, d_line, d_frame, d_vb;
  logic [11:0] d_x, d_y;
  logic        s_pix_en, s_hs, s_vs, s_blank, s_de, s_line, s_frame, s_vb;
  logic [11:0] s_x, s_y;
  logic        p_pix_en, p_hs, p_vs, p_blank, p_de, p_line, p_frame, p_vb;
  logic [11:0] p_x, p_y;

  vga_timing_gen dut_d (
    .i_clk(clk), .i_rst_n(rst_d), .o_pix_en(d_pix_en), .o_hsync(d_hs), .o_vsync(d_vs),
    .o_blank(d_blank), .o_de(d_de), .o_x(d_x), .o_y(d_y), .o_line_start(d_line),
    .o_frame_start(d_frame), .o_vblank_start(d_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CLK_DIV(1)
  ) dut_s (
    .i_clk(clk), .i_rst_n(rst_s), .o_pix_en(s_pix_en), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_blank(s_blank), .o_de(s_de), .o_x(s_x), .o_y(s_y), .o_line_start(s_line),
    .o_frame_start(s_frame), .o_vblank_start(s_vb)
  );

  vga_timing_gen #(
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .H_POL(1), .V_POL(1)
  ) dut_p (
    .i_clk(clk), .i_rst_n(rst_p), .o_pix_en(p_pix_en), .o_hsync(p_hs), .o_vsync(p_vs),
    .o_blank(p_blank), .o_de(p_de), .o_x(p_x), .o_y(p_y), .o_line_start(p_line),
    .o_frame_start(p_frame), .o_vblank_start(p_vb)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int k;
    int last_ls, min_gap, max_gap, fs_n, fs_first, fs_second, vb_t, vb_line;
    int vs_cnt, vs_first, de_cnt, max_x, max_y, gate_bad, hs_cnt, hs_first, pe_bad;
    int hs_hi, vs_hi, ls_cnt;

    // Default timing: reset values
    repeat (10) @(negedge clk);
    chk("rst_hsync", d_hs, 1);
    chk("rst_vsync", d_vs, 1);
    chk("rst_blank", d_blank, 1);
    chk("rst_de", d_de, 0);
    chk("rst_x", d_x, 0);
    chk("rst_y", d_y, 0);
    chk("rst_strobes", {d_pix_en, d_line, d_frame, d_vb}, 0);
    chk("rst_pol_hsync", p_hs, 0);
    chk("rst_pol_vsync", p_vs, 0);

    rst_d = 1'b1;
    @(negedge clk);
    chk("edge1_pix_en", d_pix_en, 0);
    @(negedge clk);
    chk("edge2_pix_en", d_pix_en, 1);
    chk("edge2_frame", d_frame, 1);
    chk("edge2_line", d_line, 1);
    chk("edge2_de", d_de, 1);
    chk("edge2_xy", {d_x, d_y}, 0);
    chk("edge2_vblank", d_vb, 0);
    @(negedge clk);
    chk("edge3_pix_en", d_pix_en, 0);
    chk("edge3_frame", d_frame, 0);
    chk("edge3_de_hold", d_de, 1);

    // Mid-frame reset inside the active area
    k = 0;
    while (!(d_pix_en && d_x == 300 && d_y == 2) && k < 10000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reach", (k < 10000), 1);
    chk("mid_de_before", d_de, 1);
    #2 rst_d = 1'b0;
    #1;
    chk("mid_async_hsync", d_hs, 1);
    chk("mid_async_blank", d_blank, 1);
    chk("mid_async_de", d_de, 0);
    chk("mid_async_xy", {d_x, d_y}, 0);
    chk("mid_async_strobes", {d_pix_en, d_line, d_frame, d_vb}, 0);
    repeat (3) @(negedge clk);
    rst_d = 1'b1;
    k = 0;
    while (!d_pix_en && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("mid_first_tick_edge", k, 2);
    chk("mid_frame_start", d_frame, 1);
    chk("mid_de", d_de, 1);
    chk("mid_xy", {d_x, d_y}, 0);

    // Small raster, CLK_DIV=1: H_TOT=14, V_TOT=7, frame=98 clocks
    rst_s = 1'b1;
    last_ls = -1; min_gap = 9999; max_gap = 0; fs_n = 0; fs_first = -1; fs_second = -1;
    vb_t = -1; vb_line = 0; vs_cnt = 0; vs_first = -1; de_cnt = 0; max_x = 0; max_y = 0;
    gate_bad = 0; hs_cnt = 0; hs_first = -1; pe_bad = 0;
    for (int c = 1; c <= 196; c++) begin
      @(negedge clk);
      if (s_line) begin
        if (last_ls > 0) begin
          if (c - last_ls < min_gap) min_gap = c - last_ls;
          if (c - last_ls > max_gap) max_gap = c - last_ls;
        end
        last_ls = c;
      end
      if (s_frame) begin
        fs_n++;
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
      end
      if (s_vb && vb_t < 0) begin
        vb_t = c;
        vb_line = s_line;
      end
      if (c <= 98) begin
        if (!s_vs) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = c;
        end
        if (s_de) de_cnt++;
      end
      if (c <= 14 && !s_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
      end
      if (s_de) begin
        if (s_x > max_x) max_x = s_x;
        if (s_y > max_y) max_y = s_y;
      end else if (s_x != 0 || s_y != 0) begin
        gate_bad++;
      end
      if (!s_pix_en) pe_bad++;
      if (c == 8) chk("s_x_last_active", {s_de, s_x}, {1'b1, 12'd7});
      if (c == 9) chk("s_x_after_active", {s_de, s_x}, 0);
    end
    chk("s_line_gap_min", min_gap, 14);
    chk("s_line_gap_max", max_gap, 14);
    chk("s_frame_count", fs_n, 2);
    chk("s_frame_first", fs_first, 1);
    chk("s_frame_gap", fs_second - fs_first, 98);
    chk("s_vblank_offset", vb_t - fs_first, 56);
    chk("s_vblank_with_line", vb_line, 1);
    chk("s_vsync_low_clocks", vs_cnt, 14);
    chk("s_vsync_first", vs_first, 71);
    chk("s_de_count", de_cnt, 32);
    chk("s_max_x", max_x, 7);
    chk("s_max_y", max_y, 3);
    chk("s_gating", gate_bad, 0);
    chk("s_hsync_low_count", hs_cnt, 3);
    chk("s_hsync_first", hs_first, 11);
    chk("s_pix_en_always", pe_bad, 0);

    // Inverted polarity, default horizontal, V=4/1/2/1, CLK_DIV=2: 12800-clock frame
    rst_p = 1'b1;
    hs_hi = 0; vs_hi = 0; vs_first = -1; de_cnt = 0; max_x = 0; max_y = 0;
    gate_bad = 0; ls_cnt = 0; fs_n = 0;
    for (int c = 1; c <= 12801; c++) begin
      @(negedge clk);
      if (c <= 4) chk("p_pix_en_pattern", p_pix_en, (c % 2 == 0) ? 1 : 0);
      if (c >= 2 && c <= 1601 && p_hs) hs_hi++;
      if (p_vs) begin
        vs_hi++;
        if (vs_first < 0) vs_first = c;
      end
      if (p_pix_en && p_de) begin
        de_cnt++;
        if (p_x > max_x) max_x = p_x;
        if (p_y > max_y) max_y = p_y;
      end
      if (!p_de && (p_x != 0 || p_y != 0)) gate_bad++;
      if (p_pix_en && p_line) ls_cnt++;
      if (p_pix_en && p_frame) fs_n++;
    end
    chk("p_hsync_high_clocks", hs_hi, 188);
    chk("p_vsync_high_clocks", vs_hi, 3200);
    chk("p_vsync_first", vs_first, 8002);
    chk("p_de_pixels", de_cnt, 2560);
    chk("p_max_x", max_x, 639);
    chk("p_max_y", max_y, 3);
    chk("p_gating", gate_bad, 0);
    chk("p_line_count", ls_cnt, 8);
    chk("p_frame_count", fs_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
